// File: rtl/move_ctrl_pkg.sv
// move_ctrl_pkg -- shared types and constants for the motion sequencer.
//   state_e   : sequencer states (IDLE, RUN_x, SETTLE_x)
//   OPER_*    : step command encoding driven onto the tracker's oper[1:0]
//   sat_inc8  : saturating 8-bit increment used by the reversal counter
package move_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN_INC    = 3'd1,
        S_RUN_DEC    = 3'd2,
        S_SETTLE_INC = 3'd3,
        S_SETTLE_DEC = 3'd4
    } state_e;

    localparam logic [1:0] OPER_HOLD = 2'b00;
    localparam logic [1:0] OPER_DEC  = 2'b01;
    localparam logic [1:0] OPER_INC  = 2'b10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/move_ctrl_step_div.sv
// step_div -- programmable step-period divider.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : force count to 0 (wins over run)
//   run        : advance count; when low the count is frozen
//   period     : clocks per tick, must be >= 1
//   tick       : high while running and count is at period-1
module step_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] count_q, count_d;

    // >= rather than == so a count left above a shortened period still wraps.
    assign tick = run && (count_q >= period - DIV_W'(1));

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (run)
            count_d = tick ? '0 : count_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/move_ctrl.sv
// move_ctrl -- motion sequencer feeding oper[1:0] of the bounded position
// tracker. Emits one-cycle INC/DEC pulses every cur_div clocks and reverses
// direction on the tracker's registered x_max/x_min flags.
//   clk, reset      : clock, asynchronous active-high reset
//   start / stop    : pulses; start latches speed_div/dir_init (IDLE only)
//   en              : level; low freezes divider and state, no step pulses
//   dir_init        : 1 = first run increments
//   speed_div       : clocks per step (0 behaves as 1)
//   x_min / x_max   : bound flags fed back from the tracker
//   oper            : 10 INC, 01 DEC, 00 HOLD (registered)
//   dir, busy       : current direction (1 = INC), state != IDLE
//   bounces         : reversals since start, saturating at 255
// Build option: MOVE_ACCEL_EN shortens the step period on every reversal,
// down to MIN_DIV, by ACCEL_STEP.
module move_ctrl
    import move_ctrl_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int MIN_DIV    = 4,
    parameter int ACCEL_STEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir_init,
    input  logic [DIV_W-1:0] speed_div,
    input  logic             x_min,
    input  logic             x_max,
    output logic [1:0]       oper,
    output logic             dir,
    output logic             busy,
    output logic [7:0]       bounces
);

    if (MIN_DIV < 1 || ACCEL_STEP < 1) begin : g_bad_cfg
        $error("move_ctrl: MIN_DIV and ACCEL_STEP must be >= 1");
    end

    state_e           state_q;
    logic [DIV_W-1:0] cur_div_q;
    logic [1:0]       oper_q;
    logic             dir_q;
    logic [7:0]       bounces_q;

    logic launch, rev_inc, rev_dec, settle_exit, run, clr, tick;
    logic [DIV_W-1:0] rev_div;

    assign launch = (state_q == S_IDLE) && start;

    // Both flags set is a tracker misconfig: x_min wins, always head to INC.
    // A flag that only means "tracker reloaded itself" is ignored.
    assign rev_inc = ((state_q == S_RUN_DEC) && x_min) ||
                     ((state_q == S_RUN_INC) && x_min && x_max);
    assign rev_dec = (state_q == S_RUN_INC) && x_max && !x_min;

    // SETTLE holds until the flag that caused the reversal drops, which
    // absorbs the tracker's one-cycle flag lag.
    assign settle_exit = ((state_q == S_SETTLE_INC) && !x_min) ||
                         ((state_q == S_SETTLE_DEC) && !x_max);

    assign run = en && (state_q != S_IDLE);
    assign clr = stop || launch || (en && settle_exit);

`ifdef MOVE_ACCEL_EN
    localparam logic [DIV_W-1:0] FLOOR = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] STEP  = DIV_W'(ACCEL_STEP);
    // Saturating subtract; a period already at/below the floor is kept.
    always_comb begin
        rev_div = cur_div_q;
        if (cur_div_q > FLOOR + STEP) rev_div = cur_div_q - STEP;
        else if (cur_div_q > FLOOR)   rev_div = FLOOR;
    end
`else
    assign rev_div = cur_div_q;
`endif

    step_div #(.DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .run    (run),
        .period (cur_div_q),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_div_q <= DIV_W'(1);
            oper_q    <= OPER_HOLD;
            dir_q     <= 1'b0;
            bounces_q <= 8'd0;
        end else begin
            oper_q <= OPER_HOLD;
            if (stop) begin
                state_q <= S_IDLE;
            end else if (launch) begin
                cur_div_q <= (speed_div == '0) ? DIV_W'(1) : speed_div;
                bounces_q <= 8'd0;
                dir_q     <= dir_init;
                state_q   <= dir_init ? S_RUN_INC : S_RUN_DEC;
            end else if (en) begin
                if (rev_inc || rev_dec) begin
                    // A tick coinciding with a reversal is dropped here.
                    state_q   <= rev_inc ? S_SETTLE_INC : S_SETTLE_DEC;
                    dir_q     <= rev_inc;
                    bounces_q <= sat_inc8(bounces_q);
                    cur_div_q <= rev_div;
                end else if (settle_exit) begin
                    state_q <= (state_q == S_SETTLE_INC) ? S_RUN_INC : S_RUN_DEC;
                end else if (tick) begin
                    if (state_q == S_RUN_INC)      oper_q <= OPER_INC;
                    else if (state_q == S_RUN_DEC) oper_q <= OPER_DEC;
                end
            end
        end
    end

    assign oper    = oper_q;
    assign dir     = dir_q;
    assign busy    = (state_q != S_IDLE);
    assign bounces = bounces_q;

endmodule

// File: tb/tb_move_ctrl.sv
module tb_move_ctrl;
    import move_ctrl_pkg::*;

    localparam int DIV_W = 16;
`ifdef MOVE_ACCEL_EN
    localparam int EXP_REV_P = 4;   // 12 - 8
`else
    localparam int EXP_REV_P = 12;  // period unchanged by a reversal
`endif

    logic             clk = 1'b0;
    logic             reset, start, stop, en, dir_init, x_min, x_max;
    logic [DIV_W-1:0] speed_div;
    logic [1:0]       oper;
    logic             dir, busy;
    logic [7:0]       bounces;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    move_ctrl #(.DIV_W(DIV_W), .MIN_DIV(4), .ACCEL_STEP(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .dir_init  (dir_init),
        .speed_div (speed_div),
        .x_min     (x_min),
        .x_max     (x_max),
        .oper      (oper),
        .dir       (dir),
        .busy      (busy),
        .bounces   (bounces)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples on falling edges until a step pulse shows; bounded.
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (oper == OPER_HOLD && n < 200);
    endtask

    // Reverse via one flag held for one clock, then measure the new period.
    task automatic rev_period(input bit use_min, output int p);
        int n;
        if (use_min) x_min = 1'b1; else x_max = 1'b1;
        @(negedge clk);
        x_min = 1'b0;
        x_max = 1'b0;
        wait_pulse(n);
        p = n - 1;
    endtask

    initial begin
        int p;
        reset = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; dir_init = 1'b0;
        x_min = 1'b0; x_max = 1'b0; speed_div = '0;

        // reset values
        @(negedge clk);
        chk("rst_oper", oper, OPER_HOLD);
        chk("rst_dir", dir, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bounces", bounces, 8'd0);
        reset = 1'b0;
        @(negedge clk);

        // period 4, increment: pulses at samples 4, 8, 12 after the start edge
        speed_div = 16'd4; dir_init = 1'b1; en = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t1_busy", busy, 1'b1);
        chk("t1_dir", dir, 1'b1);
        chk("t1_oper0", oper, OPER_HOLD);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("t1_oper_k%0d", k), oper, (k % 4 == 0) ? OPER_INC : OPER_HOLD);
        end

        // x_max for two clocks: one reversal, quiet, then DEC every 4
        x_max = 1'b1;
        @(negedge clk);                                   // 13
        chk("t2_oper13", oper, OPER_HOLD);
        chk("t2_dir", dir, 1'b0);
        chk("t2_bounces", bounces, 8'd1);
        chk("t2_busy", busy, 1'b1);
        @(negedge clk);                                   // 14
        chk("t2_oper14", oper, OPER_HOLD);
        x_max = 1'b0;
        for (int k = 15; k <= 23; k++) begin
            @(negedge clk);
            chk($sformatf("t2_oper_k%0d", k), oper, (k == 19 || k == 23) ? OPER_DEC : OPER_HOLD);
        end

        // en low for 10 clocks with count at 1: frozen, then pulse 3 clocks later
        @(negedge clk);                                   // 24
        en = 1'b0;
        for (int k = 25; k <= 34; k++) begin
            @(negedge clk);
            chk($sformatf("t4_frz_k%0d", k), oper, OPER_HOLD);
        end
        en = 1'b1;
        for (int k = 35; k <= 37; k++) begin
            @(negedge clk);
            chk($sformatf("t4_oper_k%0d", k), oper, (k == 37) ? OPER_DEC : OPER_HOLD);
        end

        // x_max alone is ignored while decrementing
        x_max = 1'b1;
        for (int k = 38; k <= 41; k++) @(negedge clk);
        chk("ign_oper", oper, OPER_DEC);
        chk("ign_bounces", bounces, 8'd1);
        chk("ign_dir", dir, 1'b0);
        x_max = 1'b0;

        // x_min in RUN_DEC: reversal to INC, pulses resume 5 clocks later
        x_min = 1'b1;
        @(negedge clk);                                   // 42
        chk("rmin_dir", dir, 1'b1);
        chk("rmin_bounces", bounces, 8'd2);
        chk("rmin_oper", oper, OPER_HOLD);
        x_min = 1'b0;
        for (int k = 43; k <= 47; k++) begin
            @(negedge clk);
            chk($sformatf("rmin_oper_k%0d", k), oper, (k == 47) ? OPER_INC : OPER_HOLD);
        end

        // both flags in RUN_INC: x_min wins -> SETTLE_INC (dir stays 1)
        x_min = 1'b1; x_max = 1'b1;
        @(negedge clk);                                   // 48
        chk("t5_dir", dir, 1'b1);
        chk("t5_bounces", bounces, 8'd3);
        chk("t5_busy", busy, 1'b1);
        chk("t5_oper", oper, OPER_HOLD);
        @(negedge clk);
        chk("t5_oper_settle", oper, OPER_HOLD);

        // stop: IDLE next clock, dir and bounces held
        stop = 1'b1; x_min = 1'b0; x_max = 1'b0;
        @(negedge clk); stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_oper", oper, OPER_HOLD);
        chk("stop_bounces", bounces, 8'd3);
        chk("stop_dir", dir, 1'b1);

        // speed_div 0 behaves as 1: INC every clock
        speed_div = 16'd0; dir_init = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t3_busy", busy, 1'b1);
        chk("t3_bounces", bounces, 8'd0);
        chk("t3_oper0", oper, OPER_HOLD);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("t3_oper_k%0d", k), oper, OPER_INC);
        end

        // async reset mid-run, observed before the next rising edge
        #2 reset = 1'b1;
        #1;
        chk("arst_oper", oper, OPER_HOLD);
        chk("arst_busy", busy, 1'b0);
        chk("arst_bounces", bounces, 8'd0);
        chk("arst_dir", dir, 1'b0);
        @(negedge clk); reset = 1'b0;

        // period after a reversal (12 without acceleration, 4 with it)
        speed_div = 16'd12; dir_init = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("per_dir0", dir, 1'b0);
        rev_period(1'b1, p);
        chk("per_after_rev", p, EXP_REV_P);
        chk("per_oper", oper, OPER_INC);
        chk("per_bounces", bounces, 8'd1);

        // bounce counter saturation: two reversals per iteration
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        speed_div = 16'd1; dir_init = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 129; i++) begin
            x_max = 1'b1; @(negedge clk);
            x_max = 1'b0; @(negedge clk);
            x_min = 1'b1; @(negedge clk);
            x_min = 1'b0; @(negedge clk);
            if (i == 126) chk("sat_254", bounces, 8'd254);
            if (i == 127) chk("sat_255", bounces, 8'd255);
        end
        chk("sat_hold", bounces, 8'd255);

`ifdef MOVE_ACCEL_EN
        // acceleration: 20 -> 12 -> 4 -> 4
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        speed_div = 16'd20; dir_init = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_pulse(p);
        chk("acc_first", p, 20);
        rev_period(1'b0, p);
        chk("acc_p1", p, 12);
        rev_period(1'b1, p);
        chk("acc_p2", p, 4);
        rev_period(1'b0, p);
        chk("acc_p3", p, 4);
`endif

        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
